pulse_meter: RTL and testbench
==============================

# pulse_meter

Consumes the single-cycle, synchronized, debounced falling-edge flag from the pulse-in debouncer and turns it into meter readings. It keeps a running pulse total and measures the clock-cycle interval between consecutive pulses, with a timeout that declares the input stalled. It also provides an atomic snapshot port so host register reads see a consistent count/period pair. It sits between the debouncer and the board's register interface on the 1.8432 MHz servo-board clock.

## Interface
- CNT_W, 32, width of pulse total
- PER_W, 24, width of period measurement
- TIMEOUT, 1843200, cycles without a pulse before stall (1 s at 1.8432 MHz); must be ≥ 2 and < 2^PER_W
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pulse  in  1  one-cycle pulse flag from debouncer
- clr  in  1  synchronous clear of count, period and state
- snap  in  1  capture request for shadow registers
- count  out  CNT_W  live pulse total
- period  out  PER_W  last valid interval in clk cycles, 0 when not valid
- period_valid  out  1  period holds a measurement
- new_period  out  1  one-cycle strobe, period just updated
- stalled  out  1  no pulse for TIMEOUT cycles
- snap_count  out  CNT_W  shadow of count
- snap_period  out  PER_W  shadow of period
- snap_valid  out  1  shadow of period_valid

## Operation
- Reset: every output is 0, state IDLE, timer 0.
- Timer:
  - On a pulse it loads 1.
  - Otherwise it increments, saturating at TIMEOUT.
  - With pulses at cycles t0 and t1, the timer reads t1−t0 at t1.
- count increments on every accepted pulse in every state and wraps modulo 2^CNT_W.
- States:
  - IDLE, pulse: go to ARMED.
  - ARMED, pulse with timer < TIMEOUT: go to RUN, with period ← timer, period_valid ← 1, new_period ← 1.
  - RUN, pulse with timer < TIMEOUT: stay in RUN and update period in the same way.
  - ARMED or RUN, timer reaches TIMEOUT with no pulse that cycle: go to STALL, with stalled ← 1, period ← 0, period_valid ← 0.
  - STALL, pulse: go to ARMED and clear stalled. The stale interval is never reported.
  - IDLE never stalls.
- A pulse in the same cycle the timer equals TIMEOUT is treated as a stall restart: go to ARMED with no period update.
- clr:
  - Forces IDLE and clears count, period, period_valid, stalled and timer.
  - clr wins over a simultaneous pulse, which is dropped and not counted.
  - The shadow registers are not affected.
- snap:
  - Loads snap_count, snap_period and snap_valid from the values those outputs hold before the edge.
  - A pulse or clr in the same cycle does not affect what is captured; it is seen only on the next snap.
- A pulse input that is high on consecutive cycles counts as one pulse per cycle; no edge detection is done here.

## Timing
- All outputs are registered.
- count, period, period_valid and stalled update one clk after the pulse or timeout cycle.
- new_period is high for exactly the one cycle in which the new period is first visible.
- Shadow outputs update one clk after snap.
- Minimum measurable period is 1 (pulses on adjacent cycles). The maximum reported is TIMEOUT−1.
- Asynchronous rst takes effect immediately, including mid-measurement. Release of rst is synchronized externally.

## Structure
- Shared package pulsemeter_pkg:
  - state enum (IDLE, ARMED, RUN, STALL)
  - default TIMEOUT constant
  - CLK_HZ = 1843200
- Sub-module period_timer: saturating counter with load-1, increment and at_max output, parameterized by PER_W and TIMEOUT.
- Top level holds the FSM, the count register and the shadow registers.

## Test plan
- Reset, then pulses at cycles 10, 110 and 310 → count=3; period=100 then 200; new_period strobes once per update; period_valid=1.
- TIMEOUT=50, a single pulse, then idle 60 cycles → stalled=1 one cycle after timer reaches 50, period=0; next pulse clears stalled and sets ARMED with no new_period.
- clr asserted in the same cycle as a pulse → count=0, state IDLE, pulse not counted, shadow registers unchanged.
- count preset near wrap (CNT_W=4, 15 pulses, then 2 more) → count reads 15, then 0, then 1.
- snap in the same cycle as a pulse that makes count 5→6 → snap_count=5, count=6; a later snap gives 6.
- Pulses on back-to-back cycles → period=1. rst asserted mid-RUN → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pulsemeter_pkg.sv
// Shared types and constants for the pulse meter.
//   state_t         : measurement FSM states
//   CLK_HZ          : servo-board clock frequency
//   DEFAULT_TIMEOUT : cycles without a pulse before stall (1 s at CLK_HZ)
package pulsemeter_pkg;

    localparam int unsigned CLK_HZ          = 1843200;
    localparam int unsigned DEFAULT_TIMEOUT = CLK_HZ;
    localparam int unsigned DEFAULT_CNT_W   = 32;
    localparam int unsigned DEFAULT_PER_W   = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_meter_period_timer.sv
// Saturating interval timer: loads 1 on a pulse, otherwise counts up and
// holds at TIMEOUT.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear to 0 (wins over load)
//   load     : pulse seen this cycle, restart at 1
//   timer    : cycles since the last pulse
//   at_max   : timer equals TIMEOUT
module period_timer
    import pulsemeter_pkg::*;
#(
    parameter int unsigned PER_W   = DEFAULT_PER_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    output logic [PER_W-1:0] timer,
    output logic             at_max
);

    assign at_max = (timer == PER_W'(TIMEOUT));

    // Loading 1 makes the value at the next pulse equal the cycle distance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (load) begin
            timer <= PER_W'(1);
        end else if (!at_max) begin
            timer <= timer + PER_W'(1);
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Pulse meter: running pulse total, interval between consecutive pulses,
// stall detection and an atomic snapshot of the readings.
//   clk, rst     : clock, async active-high reset
//   pulse        : one-cycle debounced pulse flag
//   clr          : synchronous clear of count, period, state and timer
//   snap         : capture count/period/period_valid into shadows
//   count        : live pulse total (wraps)
//   period       : last valid interval in cycles, 0 when not valid
//   period_valid : period holds a measurement
//   new_period   : one-cycle strobe when period is updated
//   stalled      : no pulse for TIMEOUT cycles
//   snap_*       : shadow copies captured on snap
module pulse_meter
    import pulsemeter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned PER_W   = DEFAULT_PER_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] count,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             new_period,
    output logic             stalled,
    output logic [CNT_W-1:0] snap_count,
    output logic [PER_W-1:0] snap_period,
    output logic             snap_valid
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   count_n;
    logic [PER_W-1:0]   period_n;
    logic               valid_n;
    logic               new_n;
    logic               stalled_n;
    logic [PER_W-1:0]   timer;
    logic               at_max;

    period_timer #(
        .PER_W   (PER_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .load   (pulse),
        .timer  (timer),
        .at_max (at_max)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            new_period   <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            period       <= period_n;
            period_valid <= valid_n;
            new_period   <= new_n;
            stalled      <= stalled_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        count_n   = count;
        period_n  = period;
        valid_n   = period_valid;
        new_n     = 1'b0;
        stalled_n = stalled;

        if (clr) begin
            // A pulse coincident with clr is dropped entirely.
            state_n   = IDLE;
            count_n   = '0;
            period_n  = '0;
            valid_n   = 1'b0;
            stalled_n = 1'b0;
        end else begin
            if (pulse) begin
                count_n = count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (pulse) begin
                        state_n = ARMED;
                    end
                end
                ARMED, RUN: begin
                    if (pulse && !at_max) begin
                        state_n  = RUN;
                        period_n = timer;
                        valid_n  = 1'b1;
                        new_n    = 1'b1;
                    end else if (pulse) begin
                        // Pulse on the timeout cycle: interval is stale,
                        // restart measurement without reporting it.
                        state_n  = ARMED;
                        period_n = '0;
                        valid_n  = 1'b0;
                    end else if (at_max) begin
                        state_n   = STALL;
                        stalled_n = 1'b1;
                        period_n  = '0;
                        valid_n   = 1'b0;
                    end
                end
                STALL: begin
                    if (pulse) begin
                        state_n   = ARMED;
                        stalled_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Shadow registers capture pre-edge outputs; clr does not touch them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_count  <= '0;
            snap_period <= '0;
            snap_valid  <= 1'b0;
        end else if (snap) begin
            snap_count  <= count;
            snap_period <= period;
            snap_valid  <= period_valid;
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter. Instance A is small (CNT_W=4, PER_W=8,
// TIMEOUT=50) for stall/wrap/snap/clr cases; instance B uses the default
// parameters for long intervals and asynchronous reset.
module tb_pulse_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, pa, ca, sa;
    logic [3:0]  cnt_a, scnt_a;
    logic [7:0]  per_a, sper_a;
    logic        val_a, new_a, stl_a, sval_a;

    logic        rst_b, pb, cb, sb;
    logic [31:0] cnt_b, scnt_b;
    logic [23:0] per_b, sper_b;
    logic        val_b, new_b, stl_b, sval_b;

    int total = 0;
    int bad   = 0;

    pulse_meter #(.CNT_W(4), .PER_W(8), .TIMEOUT(50)) u_a (
        .clk(clk), .rst(rst_a), .pulse(pa), .clr(ca), .snap(sa),
        .count(cnt_a), .period(per_a), .period_valid(val_a),
        .new_period(new_a), .stalled(stl_a), .snap_count(scnt_a),
        .snap_period(sper_a), .snap_valid(sval_a)
    );

    pulse_meter u_b (
        .clk(clk), .rst(rst_b), .pulse(pb), .clr(cb), .snap(sb),
        .count(cnt_b), .period(per_b), .period_valid(val_b),
        .new_period(new_b), .stalled(stl_b), .snap_count(scnt_b),
        .snap_period(sper_b), .snap_valid(sval_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        pa = 1'b1;
        tick();
        pa = 1'b0;
    endtask

    task automatic pulse_b();
        pb = 1'b1;
        tick();
        pb = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; pa = 1'b0; ca = 1'b0; sa = 1'b0;
        rst_b = 1'b1; pb = 1'b0; cb = 1'b0; sb = 1'b0;
        #12;
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_per_a", 32'(per_a), 0);
        chk("rst_flags_a", 32'({val_a, new_a, stl_a, sval_a}), 0);
        chk("rst_snap_a", 32'({scnt_a, sper_a}), 0);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_per_b", 32'(per_b), 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Instance B: pulses 100 then 200 cycles apart.
        repeat (9) tick();
        pulse_b();
        chk("b_p1_cnt", cnt_b, 1);
        chk("b_p1_valid", 32'(val_b), 0);
        chk("b_p1_new", 32'(new_b), 0);
        repeat (99) tick();
        pulse_b();
        chk("b_p2_cnt", cnt_b, 2);
        chk("b_p2_per", 32'(per_b), 100);
        chk("b_p2_new", 32'(new_b), 1);
        chk("b_p2_valid", 32'(val_b), 1);
        tick();
        chk("b_p2_new_drop", 32'(new_b), 0);
        chk("b_p2_per_hold", 32'(per_b), 100);
        repeat (198) tick();
        pulse_b();
        chk("b_p3_cnt", cnt_b, 3);
        chk("b_p3_per", 32'(per_b), 200);
        chk("b_p3_new", 32'(new_b), 1);

        // Asynchronous reset mid-RUN, checked away from any clock edge.
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_arst_cnt", cnt_b, 0);
        chk("b_arst_per", 32'(per_b), 0);
        chk("b_arst_flags", 32'({val_b, new_b, stl_b, sval_b}), 0);
        @(posedge clk); #1;
        rst_b = 1'b0;

        // Instance A: single pulse then stall at TIMEOUT=50.
        pulse_a();
        chk("a_p1_cnt", 32'(cnt_a), 1);
        repeat (49) tick();
        chk("a_prestall", 32'(stl_a), 0);
        tick();
        chk("a_stall", 32'(stl_a), 1);
        chk("a_stall_per", 32'(per_a), 0);
        chk("a_stall_valid", 32'(val_a), 0);
        repeat (10) tick();
        pulse_a();
        chk("a_unstall", 32'(stl_a), 0);
        chk("a_unstall_new", 32'(new_a), 0);
        chk("a_unstall_valid", 32'(val_a), 0);
        chk("a_unstall_cnt", 32'(cnt_a), 2);

        // Back-to-back pulses give period 1.
        pulse_a();
        chk("a_b2b_per", 32'(per_a), 1);
        chk("a_b2b_new", 32'(new_a), 1);
        chk("a_b2b_cnt", 32'(cnt_a), 3);
        pulse_a();
        pulse_a();
        chk("a_cnt5", 32'(cnt_a), 5);

        // snap coincident with the pulse that takes count 5 -> 6.
        pa = 1'b1; sa = 1'b1;
        tick();
        pa = 1'b0; sa = 1'b0;
        chk("a_snap_cnt", 32'(scnt_a), 5);
        chk("a_live_cnt", 32'(cnt_a), 6);
        chk("a_snap_per", 32'(sper_a), 1);
        chk("a_snap_valid", 32'(sval_a), 1);
        tick();
        sa = 1'b1;
        tick();
        sa = 1'b0;
        chk("a_snap_cnt2", 32'(scnt_a), 6);

        // clr wins over a simultaneous pulse; shadows untouched.
        pa = 1'b1; ca = 1'b1;
        tick();
        pa = 1'b0; ca = 1'b0;
        chk("a_clr_cnt", 32'(cnt_a), 0);
        chk("a_clr_per", 32'(per_a), 0);
        chk("a_clr_valid", 32'(val_a), 0);
        chk("a_clr_snap", 32'(scnt_a), 6);
        pulse_a();
        chk("a_idle_arm_cnt", 32'(cnt_a), 1);
        chk("a_idle_arm_new", 32'(new_a), 0);
        pulse_a();
        chk("a_arm_run_new", 32'(new_a), 1);
        chk("a_arm_run_per", 32'(per_a), 1);

        // Count wrap at CNT_W=4.
        ca = 1'b1;
        tick();
        ca = 1'b0;
        chk("a_wrap_clr", 32'(cnt_a), 0);
        pa = 1'b1;
        repeat (15) tick();
        chk("a_wrap_15", 32'(cnt_a), 15);
        tick();
        chk("a_wrap_0", 32'(cnt_a), 0);
        tick();
        chk("a_wrap_1", 32'(cnt_a), 1);
        pa = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
